// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: state encodings,
// opcode/funct constants, ALU control codes and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EXEC   = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_I_EXEC   = 4'd11,
      S_I_WB     = 4'd12,
      S_HALT     = 4'd15
   } state_e;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (IR[5:0]); funct 0 under opcode 0 is the halt instruction
   localparam logic [5:0] FN_HALT = 6'h00;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // ALU control codes
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU B-operand select
   localparam logic [1:0] SRCB_B    = 2'd0;
   localparam logic [1:0] SRCB_4    = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_IMM2 = 2'd3;

   // PC source select
   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;

   // True for the last state of an instruction (the one that returns to FETCH)
   function automatic logic is_final_state(input state_e s);
      return (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_R_WB) ||
             (s == S_BRANCH) || (s == S_JUMP)   || (s == S_I_WB);
   endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct decoder: maps funct to an ALU control code and flags any
// funct the CPU does not implement (including the halt encoding).
module mc_alu_dec
   import mc_ctrl_pkg::*;
#(
   parameter int FN_W = 6
) (
   input  logic [FN_W-1:0] funct,
   output logic [2:0]      alu_ctl,
   output logic            illegal
);

   // Funct lookup; unknown codes fall back to add and raise illegal
   always_comb begin
      alu_ctl = ALU_ADD;
      illegal = 1'b0;
      case (funct)
         FN_ADD:  alu_ctl = ALU_ADD;
         FN_SUB:  alu_ctl = ALU_SUB;
         FN_AND:  alu_ctl = ALU_AND;
         FN_OR:   alu_ctl = ALU_OR;
         FN_SLT:  alu_ctl = ALU_SLT;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM. Moore outputs decoded from the state register;
// the state only moves, and write enables only fire, in cycles with step=1.
// Optional performance counters are built when MC_CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W = 6,
   parameter int FN_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            step,
   input  logic [OP_W-1:0] opcode,
   input  logic [FN_W-1:0] funct,
   input  logic            zero,
   output logic            pc_write,
   output logic            pc_write_cond,
   output logic            ir_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic            iord,
   output logic            reg_write,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [2:0]      alu_ctl,
   output logic [1:0]      pc_source,
   output logic [3:0]      state_o,
   output logic            halted
`ifdef MC_CTRL_PERF_CNT_EN
  ,output logic [31:0]     cycle_cnt,
   output logic [31:0]     instr_cnt
`endif
);

   state_e     state_q, state_d, nxt;
   logic       pc_write_raw, pc_write_cond_raw, ir_write_raw;
   logic       mem_write_raw, reg_write_raw;
   logic [2:0] dec_alu_ctl;
   logic       dec_illegal;

   // The zero flag is consumed by the datapath together with pc_write_cond
   logic       unused_zero;
   assign unused_zero = zero;

   mc_alu_dec #(.FN_W(FN_W)) u_alu_dec (
      .funct   (funct),
      .alu_ctl (dec_alu_ctl),
      .illegal (dec_illegal)
   );

   // State register; reset parks the machine in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and Moore output decode
   always_comb begin
      nxt               = state_q;
      pc_write_raw      = 1'b0;
      pc_write_cond_raw = 1'b0;
      ir_write_raw      = 1'b0;
      mem_read          = 1'b0;
      mem_write_raw     = 1'b0;
      iord              = 1'b0;
      reg_write_raw     = 1'b0;
      reg_dst           = 1'b0;
      mem_to_reg        = 1'b0;
      alu_src_a         = 1'b0;
      alu_src_b         = SRCB_B;
      alu_ctl           = ALU_ADD;
      pc_source         = PCS_ALU;
      case (state_q)
         S_IDLE: nxt = S_FETCH;
         S_FETCH: begin
            mem_read     = 1'b1;
            ir_write_raw = 1'b1;
            alu_src_b    = SRCB_4;
            pc_write_raw = 1'b1;
            nxt          = S_DECODE;
         end
         S_DECODE: begin
            // Branch target computed speculatively into ALUOut
            alu_src_b = SRCB_IMM2;
            case (opcode)
               OP_LW, OP_SW: nxt = S_MEM_ADDR;
               OP_RTYPE:     nxt = S_R_EXEC;
               OP_BEQ:       nxt = S_BRANCH;
               OP_J:         nxt = S_JUMP;
               OP_ADDI:      nxt = S_I_EXEC;
               default:      nxt = S_HALT;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            if (opcode == OP_LW)      nxt = S_MEM_RD;
            else if (opcode == OP_SW) nxt = S_MEM_WR;
            else                      nxt = S_HALT;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            nxt      = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = 1'b1;
            nxt           = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write_raw = 1'b1;
            iord          = 1'b1;
            nxt           = S_FETCH;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_ctl   = dec_alu_ctl;
            // Halt instruction and unsupported funct codes both stop the CPU
            nxt       = dec_illegal ? S_HALT : S_R_WB;
         end
         S_R_WB: begin
            reg_write_raw = 1'b1;
            reg_dst       = 1'b1;
            nxt           = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a         = 1'b1;
            alu_ctl           = ALU_SUB;
            pc_write_cond_raw = 1'b1;
            pc_source         = PCS_ALUOUT;
            nxt               = S_FETCH;
         end
         S_JUMP: begin
            pc_write_raw = 1'b1;
            pc_source    = PCS_JUMP;
            nxt          = S_FETCH;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            nxt       = S_I_WB;
         end
         S_I_WB: begin
            reg_write_raw = 1'b1;
            nxt           = S_FETCH;
         end
         S_HALT:  nxt = S_HALT;
         default: nxt = S_HALT;
      endcase
      state_d = step ? nxt : state_q;
   end

   // Commits are qualified by step so a held state never writes twice
   assign pc_write      = pc_write_raw      & step;
   assign pc_write_cond = pc_write_cond_raw & step;
   assign ir_write      = ir_write_raw      & step;
   assign mem_write     = mem_write_raw     & step;
   assign reg_write     = reg_write_raw     & step;
   assign state_o       = state_q;
   assign halted        = (state_q == S_HALT);

`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] instr_cnt_q, instr_cnt_d;

   // Counter next values: active qualified steps and retired instructions
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (step && (state_q != S_IDLE) && (state_q != S_HALT))
         cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (step && is_final_state(state_q))
         instr_cnt_d = instr_cnt_q + 32'd1;
   end

   // Counter registers, wrap naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`else
   // No performance counters in this build
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed vector table, hand sequences
// for step-hold, halt, reset and counters, then random instruction streams
// checked against an instruction-level reference model.
module tb_mc_ctrl_fsm;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       step = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord;
   logic       reg_write, reg_dst, mem_to_reg, alu_src_a, halted;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_ctl;
   logic [3:0] state_o;
`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif
   logic [4:0] wen;

   int total = 0;
   int bad = 0;

   assign wen = {pc_write, pc_write_cond, ir_write, mem_write, reg_write};

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.OP_W(6), .FN_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .step(step), .opcode(opcode), .funct(funct),
      .zero(zero), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctl(alu_ctl), .pc_source(pc_source), .state_o(state_o),
      .halted(halted)
`ifdef MC_CTRL_PERF_CNT_EN
     ,.cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   typedef struct {
      logic       stp;
      logic [5:0] op;
      logic [5:0] fn;
      logic [3:0] st;
      logic [4:0] wen;
      logic       mr;
      logic       mtr;
      logic       rdst;
      logic [1:0] pcs;
      logic [2:0] ab;
      logic [2:0] alu;
      logic       achk;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic [5:0] o, input logic [5:0] f,
                               input logic [3:0] st, input logic [4:0] w, input logic mr,
                               input logic mtr, input logic rd, input logic [1:0] pcs,
                               input logic [2:0] ab, input logic [2:0] alu, input logic achk);
      vec_t v;
      v.stp = s; v.op = o; v.fn = f; v.st = st; v.wen = w; v.mr = mr; v.mtr = mtr;
      v.rdst = rd; v.pcs = pcs; v.ab = ab; v.alu = alu; v.achk = achk;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step  = 1'b0;
      #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_memread", 32'(mem_read), 32'd0);
      repeat (2) adv();
      rst_n = 1'b1;
      #1;
   endtask

   // Spec-level expectation of which commits each state performs
   function automatic logic [4:0] exp_wen(input int st);
      case (st)
         1:       return 5'b10100;
         5, 8, 12: return 5'b00001;
         6:       return 5'b00010;
         9:       return 5'b01000;
         10:      return 5'b10000;
         default: return 5'b00000;
      endcase
   endfunction

   function automatic logic [2:0] fn_alu(input logic [5:0] f);
      case (f)
         6'h20:   return 3'b010;
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         default: return 3'b111;
      endcase
   endfunction

   vec_t tbl[20];

   initial begin
      logic [5:0] fn_pool[5];
      int q[$];
      logic [2:0] cur_alu;

      tbl[0]  = mk(1, OP_LW, 0, 0, 5'b00000, 0, 0, 0, 0, 3'b000, 3'b010, 1);
      tbl[1]  = mk(0, OP_LW, 0, 1, 5'b00000, 1, 0, 0, 0, 3'b001, 3'b010, 1);
      tbl[2]  = mk(1, OP_LW, 0, 1, 5'b10100, 1, 0, 0, 0, 3'b001, 3'b010, 1);
      tbl[3]  = mk(1, OP_LW, 0, 2, 5'b00000, 0, 0, 0, 0, 3'b011, 3'b010, 1);
      tbl[4]  = mk(1, OP_LW, 0, 3, 5'b00000, 0, 0, 0, 0, 3'b110, 3'b010, 1);
      tbl[5]  = mk(1, OP_LW, 0, 4, 5'b00000, 1, 0, 0, 0, 3'b000, 3'b010, 0);
      tbl[6]  = mk(1, OP_LW, 0, 5, 5'b00001, 0, 1, 0, 0, 3'b000, 3'b010, 0);
      tbl[7]  = mk(1, OP_RTYPE, 6'h20, 1, 5'b10100, 1, 0, 0, 0, 3'b001, 3'b010, 1);
      tbl[8]  = mk(1, OP_RTYPE, 6'h20, 2, 5'b00000, 0, 0, 0, 0, 3'b011, 3'b010, 1);
      tbl[9]  = mk(1, OP_RTYPE, 6'h20, 7, 5'b00000, 0, 0, 0, 0, 3'b100, 3'b010, 1);
      tbl[10] = mk(1, OP_RTYPE, 6'h20, 8, 5'b00001, 0, 0, 1, 0, 3'b000, 3'b010, 0);
      tbl[11] = mk(1, OP_RTYPE, 6'h22, 1, 5'b10100, 1, 0, 0, 0, 3'b001, 3'b010, 1);
      tbl[12] = mk(1, OP_RTYPE, 6'h22, 2, 5'b00000, 0, 0, 0, 0, 3'b011, 3'b010, 1);
      tbl[13] = mk(1, OP_RTYPE, 6'h22, 7, 5'b00000, 0, 0, 0, 0, 3'b100, 3'b110, 1);
      tbl[14] = mk(1, OP_RTYPE, 6'h22, 8, 5'b00001, 0, 0, 1, 0, 3'b000, 3'b010, 0);
      tbl[15] = mk(1, OP_SW, 0, 1, 5'b10100, 1, 0, 0, 0, 3'b001, 3'b010, 1);
      tbl[16] = mk(1, OP_SW, 0, 2, 5'b00000, 0, 0, 0, 0, 3'b011, 3'b010, 1);
      tbl[17] = mk(1, OP_SW, 0, 3, 5'b00000, 0, 0, 0, 0, 3'b110, 3'b010, 1);
      tbl[18] = mk(1, OP_SW, 0, 6, 5'b00010, 0, 0, 0, 0, 3'b000, 3'b010, 0);
      tbl[19] = mk(0, OP_SW, 0, 1, 5'b00000, 1, 0, 0, 0, 3'b001, 3'b010, 1);

      fn_pool[0] = 6'h20; fn_pool[1] = 6'h22; fn_pool[2] = 6'h24;
      fn_pool[3] = 6'h25; fn_pool[4] = 6'h2A;

      #2;
      do_reset();

      // Directed vector table: lw, add, sub, sw, with step holds
      for (int i = 0; i < 20; i++) begin
         step = tbl[i].stp; opcode = tbl[i].op; funct = tbl[i].fn;
         #1;
         chk($sformatf("v%0d_state", i), 32'(state_o), 32'(tbl[i].st));
         chk($sformatf("v%0d_wen", i), 32'(wen), 32'(tbl[i].wen));
         chk($sformatf("v%0d_memrd", i), 32'(mem_read), 32'(tbl[i].mr));
         chk($sformatf("v%0d_m2r", i), 32'(mem_to_reg), 32'(tbl[i].mtr));
         chk($sformatf("v%0d_rdst", i), 32'(reg_dst), 32'(tbl[i].rdst));
         chk($sformatf("v%0d_pcsrc", i), 32'(pc_source), 32'(tbl[i].pcs));
         chk($sformatf("v%0d_srcab", i), 32'({alu_src_a, alu_src_b}), 32'(tbl[i].ab));
         if (tbl[i].achk) chk($sformatf("v%0d_alu", i), 32'(alu_ctl), 32'(tbl[i].alu));
         adv();
      end

      // beq with zero=1: FETCH, DECODE, BRANCH, back to FETCH
      step = 1'b1; opcode = OP_BEQ; zero = 1'b1;
      #1; chk("beq_fetch", 32'(state_o), 32'd1);
      adv(); chk("beq_decode", 32'(state_o), 32'd2);
      adv();
      chk("beq_state", 32'(state_o), 32'd9);
      chk("beq_pwc", 32'(pc_write_cond), 32'd1);
      chk("beq_pcsrc", 32'(pc_source), 32'd1);
      chk("beq_alu", 32'(alu_ctl), 32'b110);
      step = 1'b0; #1;
      chk("beq_hold_pwc", 32'(pc_write_cond), 32'd0);
      step = 1'b1;
      adv(); chk("beq_ret", 32'(state_o), 32'd1);

      // Undefined opcode halts; HALT absorbs steps until reset
      opcode = 6'h3F;
      adv(); adv();
      chk("halt_state", 32'(state_o), 32'd15);
      chk("halt_flag", 32'(halted), 32'd1);
      repeat (10) adv();
      chk("halt_stay", 32'(state_o), 32'd15);
      chk("halt_wen", 32'(wen), 32'd0);
      chk("halt_alu", 32'(alu_ctl), 32'b010);
      chk("halt_memrd", 32'(mem_read), 32'd0);
      do_reset();
      chk("post_halt_state", 32'(state_o), 32'd0);

      // Reset asserted mid-instruction, in MEM_WB with step high
      step = 1'b1; opcode = OP_LW;
      repeat (5) adv();
      chk("mid_state", 32'(state_o), 32'd5);
      chk("mid_regw", 32'(reg_write), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_regw", 32'(reg_write), 32'd0);
      chk("abort_state", 32'(state_o), 32'd0);
      adv();
      rst_n = 1'b1;

      // Halt instruction (opcode 0, funct 0) and unsupported funct
      for (int k = 0; k < 2; k++) begin
         step = 1'b1; opcode = OP_RTYPE; funct = (k == 0) ? 6'h00 : 6'h3F;
         repeat (4) adv();
         chk($sformatf("rhalt%0d_state", k), 32'(state_o), 32'd15);
         chk($sformatf("rhalt%0d_flag", k), 32'(halted), 32'd1);
         do_reset();
      end

`ifdef MC_CTRL_PERF_CNT_EN
      // addi then j: 7 active steps, 2 retired instructions
      step = 1'b1; opcode = OP_ADDI;
      repeat (5) adv();
      chk("perf_mid_state", 32'(state_o), 32'd1);
      opcode = OP_J;
      repeat (3) adv();
      chk("perf_end_state", 32'(state_o), 32'd1);
      chk("perf_instr", instr_cnt, 32'd2);
      chk("perf_cycle", cycle_cnt, 32'd7);
      do_reset();
      chk("perf_rst_cycle", cycle_cnt, 32'd0);
`endif

      // Random instruction stream against the instruction-level model
      q.delete();
      q.push_back(0);
      cur_alu = 3'b010;
      for (int c = 0; c < 800; c++) begin
         if (q.size() == 0) begin
            int k;
            k = $urandom_range(0, 5);
            q.push_back(1); q.push_back(2);
            case (k)
               0: begin opcode = OP_LW;   q.push_back(3); q.push_back(4); q.push_back(5); end
               1: begin opcode = OP_SW;   q.push_back(3); q.push_back(6); end
               2: begin
                  opcode = OP_RTYPE; funct = fn_pool[$urandom_range(0, 4)];
                  cur_alu = fn_alu(funct);
                  q.push_back(7); q.push_back(8);
               end
               3: begin opcode = OP_BEQ;  q.push_back(9); end
               4: begin opcode = OP_J;    q.push_back(10); end
               default: begin opcode = OP_ADDI; q.push_back(11); q.push_back(12); end
            endcase
         end
         step = ($urandom_range(0, 3) != 0);
         zero = 1'($urandom_range(0, 1));
         #1;
         chk("rnd_state", 32'(state_o), 32'(q[0]));
         chk("rnd_wen", 32'(wen), 32'(exp_wen(q[0]) & {5{step}}));
         chk("rnd_memrd", 32'(mem_read), 32'((q[0] == 1) || (q[0] == 4)));
         if (q[0] == 7) chk("rnd_alu", 32'(alu_ctl), 32'(cur_alu));
         adv();
         if (step) void'(q.pop_front());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the term-project CPU.
- Sequences the shared datapath (single memory, single ALU, register file, IR, PC) through fetch/decode/execute/memory/writeback states.
- Decodes the 6-bit opcode and funct, and drives all datapath enables and muxes.
- Advances only on a qualified step, so the board's single-step switch and free-run mode both work.
- Sits between the IR and the datapath inside the CPU top.

Parameters:
- OP_W, 6, opcode field width.
- FN_W, 6, funct field width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- step  in  1  advance enable; FSM moves and writes commit only in cycles with step=1.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- ir_write  out  1  IR load.
- mem_read  out  1  memory read.
- mem_write  out  1  memory write.
- iord  out  1  memory address source: 0=PC, 1=ALUOut.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination: 0=rt, 1=rd.
- mem_to_reg  out  1  write-back source: 0=ALUOut, 1=MDR.
- alu_src_a  out  1  ALU A source: 0=PC, 1=A.
- alu_src_b  out  2  ALU B source: 0=B, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2.
- alu_ctl  out  3  ALU control: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_source  out  2  PC source: 0=ALU, 1=ALUOut, 2=jump target.
- state_o  out  4  current state, for the Output_Data display mux.
- halted  out  1  FSM parked in HALT.

Behaviour:
- State register: 4 bits.
  - Async reset clears it to IDLE.
  - Next state is taken only on posedge clk with step=1; otherwise it holds.
- Outputs:
  - Moore outputs, decoded combinationally from state.
  - Every write-type output (pc_write, pc_write_cond, ir_write, mem_write, reg_write) is ANDed with step, so a held state never double-commits.
  - In IDLE and HALT every output is 0, and alu_ctl is 010.
  - During reset: all outputs 0, state_o=0, halted=0.
- IDLE -> FETCH.
- FETCH: mem_read, ir_write, alu_src_b=1, alu add, pc_source=0, pc_write. Next: DECODE.
- DECODE: alu_src_b=3, add (branch target into ALUOut). Next state by opcode:
  - 100011/101011 -> MEM_ADDR.
  - 000000 -> R_EXEC.
  - 000100 -> BRANCH.
  - 000010 -> JUMP.
  - 001000 -> I_EXEC.
  - Any other opcode -> HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add. Next: MEM_RD if lw, MEM_WR if sw.
- MEM_RD: mem_read, iord. Next: MEM_WB.
- MEM_WB: reg_write, mem_to_reg, reg_dst=0. Next: FETCH.
- MEM_WR: mem_write, iord. Next: FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_ctl from funct:
  - 100000 -> add; 100010 -> sub; 100100 -> and; 100101 -> or; 101010 -> slt.
  - Funct 000000 with opcode 000000 is a halt instruction -> HALT.
  - Any other funct -> HALT.
  - Valid funct -> R_WB.
- R_WB: reg_write, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_write_cond, pc_source=1. Next: FETCH.
- JUMP: pc_write, pc_source=2. Next: FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, add. Next: I_WB.
- I_WB: reg_write, reg_dst=0, mem_to_reg=0. Next: FETCH.
- HALT: absorbing; only reset leaves it. halted=1.
- Reset mid-instruction aborts immediately; no partial write occurs because outputs go low with state.
- CPI: lw 5, sw 4, R 4, addi 4, beq 3, j 3 qualified steps. Plus one step from IDLE after reset.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both async-cleared.
  - cycle_cnt increments on every qualified step outside IDLE/HALT.
  - instr_cnt increments on each qualified step leaving a final state into FETCH.
  - Both wrap 0xFFFFFFFF -> 0.
- Undefined: the ports are absent and no counter logic is built.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12, HALT=15;
  - opcode and funct constants;
  - alu_ctl codes.
- One sub-module, mc_alu_dec: combinational mapping of funct to alu_ctl plus an illegal flag, used by R_EXEC.

Test Plan:
- Reset, then 1 step -> state_o=1, ir_write=1 and pc_write=1 while step=1; step=0 -> both write enables 0 and state holds at 1.
- lw (opcode 0x23): 5 steps -> sequence 1,2,3,4,5,1; reg_write=1 and mem_to_reg=1 only in state 5.
- R add (funct 0x20) then sub (0x22) -> alu_ctl 010 then 110 in R_EXEC; R_WB has reg_dst=1.
- beq with zero=1 -> pc_write_cond=1 and pc_source=1 in state 9; returns to 1 after 3 steps total.
- opcode 0x3F -> DECODE->HALT, halted=1; 10 more steps leave state 15; rst_n pulse low -> state 0.
- With MC_CTRL_PERF_CNT_EN, addi + j -> instr_cnt=2, cycle_cnt=7.
